// File: rtl/conv_stream_host.sv
`default_nettype none
// ============================================================================
// Module   : conv_stream_host
// Purpose  : Loads an X-word vector, streams it to a conv layer, and collects
//            the X-F+1 results into an address-readable buffer.
// Revision : 1.0 - initial release
// ============================================================================
module conv_stream_host #(
    parameter int X = 16,
    parameter int F = 4,
    parameter int W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [W-1:0]             ld_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [W-1:0]             s_data,
    output logic                     s_valid,
    input  logic                     s_ready,
    input  logic [W-1:0]             r_data,
    input  logic                     r_valid,
    output logic                     r_ready,
    input  logic [$clog2(X-F+1)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    localparam int Y   = X - F + 1;
    localparam int XW  = (X > 1) ? $clog2(X) : 1;
    localparam int YAW = $clog2(Y);
    localparam int RCW = $clog2(Y + 1);

    localparam logic [XW-1:0]  c_X_LAST = XW'(X - 1);
    localparam logic [RCW-1:0] c_Y_CNT  = RCW'(Y);
    localparam logic [RCW-1:0] c_Y_LAST = RCW'(Y - 1);

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_ARMED = 3'd1,
        ST_SEND  = 3'd2,
        ST_RECV  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [XW-1:0]   r_ld_cnt;
    logic [XW-1:0]   r_s_idx;
    logic [RCW-1:0]  r_r_cnt;
    logic            r_done;
    logic [W-1:0]    r_rd_data;
    logic [W-1:0]    r_xbuf [X];
    logic [W-1:0]    r_ybuf [Y];

    logic            w_ld_fire;
    logic            w_s_fire;
    logic            w_r_fire;
    logic            w_rd_in_range;
    logic [W-1:0]    w_rd_word;
    logic [RCW-1:0]  w_r_cnt_next;

    // Once all Y results are in during SEND, stop accepting so the buffer
    // index can never run past the end.
    assign ld_ready = (r_state == ST_LOAD);
    assign s_valid  = (r_state == ST_SEND);
    assign r_ready  = ((r_state == ST_SEND) && (r_r_cnt != c_Y_CNT)) ||
                      (r_state == ST_RECV);
    assign busy     = (r_state == ST_SEND) || (r_state == ST_RECV);
    assign done     = r_done;
    assign s_data   = r_xbuf[r_s_idx];
    assign rd_data  = r_rd_data;

    assign w_ld_fire     = ld_valid & ld_ready;
    assign w_s_fire      = s_valid & s_ready;
    assign w_r_fire      = r_valid & r_ready;
    assign w_r_cnt_next  = r_r_cnt + RCW'(w_r_fire);
    assign w_rd_in_range = (int'(rd_addr) < Y);
    assign w_rd_word     = w_rd_in_range ? r_ybuf[rd_addr] : '0;

    // Buffers carry no reset; their contents survive until overwritten.
    always_ff @(posedge clk) begin
        if (w_ld_fire) begin
            r_xbuf[r_ld_cnt] <= ld_data;
        end
        if (w_r_fire) begin
            r_ybuf[r_r_cnt[YAW-1:0]] <= r_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_LOAD;
            r_ld_cnt  <= '0;
            r_s_idx   <= '0;
            r_r_cnt   <= '0;
            r_done    <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_done    <= 1'b0;
            r_rd_data <= w_rd_word;
            case (r_state)
                ST_LOAD: begin
                    if (w_ld_fire) begin
                        if (r_ld_cnt == c_X_LAST) begin
                            r_ld_cnt <= '0;
                            r_state  <= ST_ARMED;
                        end else begin
                            r_ld_cnt <= r_ld_cnt + XW'(1);
                        end
                    end
                end
                ST_ARMED: begin
                    if (start) begin
                        r_s_idx <= '0;
                        r_r_cnt <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_r_cnt <= w_r_cnt_next;
                    if (w_s_fire) begin
                        if (r_s_idx == c_X_LAST) begin
                            r_s_idx <= '0;
                            // All results may already be in: skip RECV.
                            if (w_r_cnt_next == c_Y_CNT) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_RECV;
                            end
                        end else begin
                            r_s_idx <= r_s_idx + XW'(1);
                        end
                    end
                end
                ST_RECV: begin
                    r_r_cnt <= w_r_cnt_next;
                    if (w_r_fire && (r_r_cnt == c_Y_LAST)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_LOAD;
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
